// File: rtl/exp_req_ctrl_pkg.sv
// Shared definitions for the exception request controller: FSM encoding,
// cause width and drop counter saturation value.
// Latency: n/a (types and constants only). Backpressure: n/a.
package exp_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  localparam int CAUSE_W = 2;
  localparam int DROP_W  = 16;
  localparam logic [DROP_W-1:0] DROP_SAT = 16'hFFFF;

endpackage

// File: rtl/exp_req_ctrl_if.sv
// Bundle between the exception request controller and its environment:
// raw events + mask and CPU ack/done in; request, cause, status out.
// master = controller side, slave = CPU/top-level side.
interface exp_req_ctrl_if #(
  parameter int N_SRC = 3
);
  logic [N_SRC-1:0]                 evt_in;
  logic [N_SRC-1:0]                 evt_mask;
  logic                             int_ack;
  logic                             int_done;
  logic [N_SRC-1:0]                 exp_src;
  logic [exp_ctrl_pkg::CAUSE_W-1:0] exp_cause;
  logic                             busy;
  logic [N_SRC-1:0]                 pending;
  logic [exp_ctrl_pkg::DROP_W-1:0]  drop_count;

  modport master (
    input  evt_in, evt_mask, int_ack, int_done,
    output exp_src, exp_cause, busy, pending, drop_count
  );

  modport slave (
    output evt_in, evt_mask, int_ack, int_done,
    input  exp_src, exp_cause, busy, pending, drop_count
  );
endinterface

// File: rtl/exp_req_ctrl_evt_debounce.sv
// Per-source front end: synchronizer, debounce counter, rise detector.
// Latency: evt_q is high in the cycle before the debounced level rises,
// SYNC_STAGES+DEB_CYCLES-1 edges after evt_in is first sampled. No backpressure.
// Ports: clk, rst, evt_in (async raw line) -> evt_q (one-cycle qualify pulse).
module evt_debounce #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic evt_in,
  output logic evt_q
);
  localparam int CNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES);

  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_W-1:0]       deb_cnt;
  logic                   evt_s;

  assign evt_s = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync    <= '0;
      deb_cnt <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], evt_in};
      if (!evt_s)
        deb_cnt <= '0;
      else if (deb_cnt != CNT_MAX)
        deb_cnt <= deb_cnt + CNT_W'(1);
    end
  end

  // Fires on the cycle whose edge takes deb_cnt to DEB_CYCLES, so the
  // pending bit sets on the same edge the debounced level goes high.
  // Saturation at CNT_MAX guarantees a held line fires only once.
  assign evt_q = evt_s && (deb_cnt == CNT_MAX - CNT_W'(1));

endmodule

// File: rtl/exp_req_ctrl.sv
// Exception request controller: debounces event lines, latches pending,
// presents one fixed-priority request at a time until int_ack, then waits int_done.
// Latency: exp_src one edge after eligible; request held until acked. No backpressure.
// Ports: clk, rst (async active-high), bus (exp_req_ctrl_if.master).
module exp_req_ctrl
  import exp_ctrl_pkg::*;
#(
  parameter int N_SRC       = 3,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4
) (
  input  logic               clk,
  input  logic               rst,
  exp_req_ctrl_if.master     bus
);
  logic [N_SRC-1:0]   evt_q;
  logic [N_SRC-1:0]   pend_r, pend_nxt, eligible, grant_clr, drop_vec;
  logic [DROP_W-1:0]  drop_r, drop_nxt;
  logic [N_SRC-1:0]   src_r;
  logic               busy_r;
  logic [CAUSE_W-1:0] win, win_nxt, pri_idx;
  logic               pri_vld;
  state_t             state, state_nxt;

  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    evt_debounce #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEB_CYCLES  (DEB_CYCLES)
    ) u_deb (
      .clk    (clk),
      .rst    (rst),
      .evt_in (bus.evt_in[i]),
      .evt_q  (evt_q[i])
    );
  end

  // Masking only gates arbitration; masked events still latch.
  assign eligible = pend_r & bus.evt_mask;

  // Lowest index wins: scan downward so the last hit is the lowest.
  always_comb begin
    pri_idx = '0;
    pri_vld = 1'b0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        pri_idx = CAUSE_W'(i);
        pri_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    win_nxt   = win;
    grant_clr = '0;
    case (state)
      ST_IDLE: begin
        if (pri_vld) begin
          win_nxt   = pri_idx;
          state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        // No preemption: once latched, win is held until ack or withdrawal.
        if (bus.int_ack) begin
          grant_clr = N_SRC'(1) << win;
          state_nxt = ST_SERVICE;
        end else if (!eligible[win]) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (bus.int_done)
          state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Set beats the grant clear; a set landing on an already-pending bit
  // (not being cleared this cycle) is a lost event.
  always_comb begin
    drop_vec = evt_q & pend_r & ~grant_clr;
    pend_nxt = (pend_r & ~grant_clr) | evt_q;
    drop_nxt = drop_r;
    for (int i = 0; i < N_SRC; i++) begin
      if (drop_vec[i] && drop_nxt != DROP_SAT)
        drop_nxt = drop_nxt + DROP_W'(1);
    end
  end

  // Outputs are decoded from the next state so they change on the same
  // edge as the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      win    <= '0;
      pend_r <= '0;
      drop_r <= '0;
      src_r  <= '0;
      busy_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      win    <= win_nxt;
      pend_r <= pend_nxt;
      drop_r <= drop_nxt;
      src_r  <= (state_nxt == ST_REQ) ? (N_SRC'(1) << win_nxt) : '0;
      busy_r <= (state_nxt == ST_SERVICE);
    end
  end

  assign bus.exp_src    = src_r;
  assign bus.exp_cause  = win;
  assign bus.busy       = busy_r;
  assign bus.pending    = pend_r;
  assign bus.drop_count = drop_r;

endmodule

// File: tb/tb_exp_req_ctrl.sv
// Bench for exp_req_ctrl: directed stimulus, grant scoreboard plus level checks.
module tb_exp_req_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  exp_req_ctrl_if #(.N_SRC(3)) bus();

  exp_req_ctrl #(
    .N_SRC       (3),
    .SYNC_STAGES (2),
    .DEB_CYCLES  (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [4:0] exp_q[$];   // {exp_src, exp_cause} expected at each new request
  logic [4:0] exp_e;
  logic [2:0] prev_src;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ack_pulse();
    bus.int_ack = 1'b1;
    step(1);
    bus.int_ack = 1'b0;
  endtask

  task automatic done_pulse();
    bus.int_done = 1'b1;
    step(1);
    bus.int_done = 1'b0;
  endtask

  // Monitor: every fresh request presentation is checked against the queue.
  initial begin
    prev_src = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_src = '0;
      end else begin
        if (bus.exp_src != 3'b000 && prev_src == 3'b000) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL grant_unexpected: got src=%b cause=%0d, expected no request",
                     bus.exp_src, bus.exp_cause);
          end else begin
            exp_e = exp_q.pop_front();
            chk("grant", {27'd0, bus.exp_src, bus.exp_cause}, {27'd0, exp_e});
          end
        end
        prev_src = bus.exp_src;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst          = 1'b1;
    bus.evt_in   = 3'b000;
    bus.evt_mask = 3'b111;
    bus.int_ack  = 1'b0;
    bus.int_done = 1'b0;
    step(2);
    chk("rst_exp_src", bus.exp_src, 0);
    chk("rst_cause", bus.exp_cause, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_pending", bus.pending, 0);
    chk("rst_drop", bus.drop_count, 0);

    // 1: single source latency and handshake
    rst = 1'b0;
    bus.evt_in = 3'b001;
    exp_q.push_back({3'b001, 2'd0});
    step(5);
    chk("t1_pending_e5", bus.pending, 3'b000);
    step(1);
    chk("t1_pending_e6", bus.pending, 3'b001);
    chk("t1_src_e6", bus.exp_src, 3'b000);
    step(1);
    chk("t1_src_e7", bus.exp_src, 3'b001);
    chk("t1_cause", bus.exp_cause, 0);
    bus.evt_in = 3'b000;
    ack_pulse();
    chk("t1_src_ack", bus.exp_src, 3'b000);
    chk("t1_busy_ack", bus.busy, 1);
    chk("t1_pending_ack", bus.pending, 3'b000);
    done_pulse();
    chk("t1_busy_done", bus.busy, 0);

    // 2: short pulse rejected, long pulse accepted
    bus.evt_in = 3'b100;
    step(3);
    bus.evt_in = 3'b000;
    step(10);
    chk("t2_short_pending", bus.pending, 3'b000);
    chk("t2_short_src", bus.exp_src, 3'b000);
    exp_q.push_back({3'b100, 2'd2});
    bus.evt_in = 3'b100;
    step(6);
    bus.evt_in = 3'b000;
    chk("t2_long_pending", bus.pending, 3'b100);
    step(1);
    chk("t2_long_src", bus.exp_src, 3'b100);
    ack_pulse();
    done_pulse();

    // 3: simultaneous events, priority and back-to-back spacing
    exp_q.push_back({3'b010, 2'd1});
    exp_q.push_back({3'b100, 2'd2});
    bus.evt_in = 3'b110;
    step(6);
    chk("t3_pending", bus.pending, 3'b110);
    bus.evt_in = 3'b000;
    step(1);
    chk("t3_src_first", bus.exp_src, 3'b010);
    chk("t3_cause_first", bus.exp_cause, 1);
    ack_pulse();
    chk("t3_pending_ack", bus.pending, 3'b100);
    done_pulse();
    chk("t3_src_gap", bus.exp_src, 3'b000);
    step(1);
    chk("t3_src_second", bus.exp_src, 3'b100);
    chk("t3_cause_second", bus.exp_cause, 2);
    ack_pulse();
    done_pulse();

    // 4: mask withdrawn during REQ
    exp_q.push_back({3'b010, 2'd1});
    bus.evt_in = 3'b010;
    step(7);
    bus.evt_in = 3'b000;
    chk("t4_src_req", bus.exp_src, 3'b010);
    bus.evt_mask = 3'b101;
    step(1);
    chk("t4_src_masked", bus.exp_src, 3'b000);
    chk("t4_pending_masked", bus.pending, 3'b010);
    step(3);
    chk("t4_src_still_masked", bus.exp_src, 3'b000);
    exp_q.push_back({3'b010, 2'd1});
    bus.evt_mask = 3'b111;
    step(1);
    chk("t4_src_unmasked", bus.exp_src, 3'b010);
    ack_pulse();
    done_pulse();
    chk("t4_pending_clear", bus.pending, 3'b000);

    // 5: drop counting and set-wins on the ack cycle
    exp_q.push_back({3'b001, 2'd0});
    bus.evt_in = 3'b001;
    step(6);
    bus.evt_in = 3'b000;
    step(4);
    chk("t5_drop_before", bus.drop_count, 0);
    bus.evt_in = 3'b001;
    step(6);
    chk("t5_drop_one", bus.drop_count, 1);
    chk("t5_pending_drop", bus.pending, 3'b001);
    bus.evt_in = 3'b000;
    step(4);
    bus.evt_in = 3'b001;
    step(5);
    bus.int_ack = 1'b1;
    step(1);
    bus.int_ack = 1'b0;
    chk("t5_set_wins", bus.pending, 3'b001);
    chk("t5_drop_unchanged", bus.drop_count, 1);
    chk("t5_busy", bus.busy, 1);
    bus.evt_in = 3'b000;
    exp_q.push_back({3'b001, 2'd0});
    done_pulse();
    step(1);
    chk("t5_src_regrant", bus.exp_src, 3'b001);
    ack_pulse();
    done_pulse();
    chk("t5_pending_clear", bus.pending, 3'b000);

    // 6: async reset in SERVICE with pending 101
    exp_q.push_back({3'b100, 2'd2});
    bus.evt_in = 3'b100;
    step(7);
    chk("t6_src_req", bus.exp_src, 3'b100);
    bus.evt_in = 3'b000;
    ack_pulse();
    chk("t6_busy", bus.busy, 1);
    step(3);
    bus.evt_in = 3'b101;
    step(6);
    bus.evt_in = 3'b000;
    chk("t6_pending_pre", bus.pending, 3'b101);
    chk("t6_drop_pre", bus.drop_count, 1);
    chk("t6_cause_pre", bus.exp_cause, 2);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_src", bus.exp_src, 0);
    chk("t6_rst_cause", bus.exp_cause, 0);
    chk("t6_rst_busy", bus.busy, 0);
    chk("t6_rst_pending", bus.pending, 0);
    chk("t6_rst_drop", bus.drop_count, 0);
    step(1);
    rst = 1'b0;
    done_pulse();
    chk("t6_done_busy", bus.busy, 0);
    chk("t6_done_src", bus.exp_src, 0);
    step(10);
    chk("t6_quiet_src", bus.exp_src, 0);
    chk("t6_quiet_pending", bus.pending, 0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/exp_req_ctrl.md
# exp_req_ctrl

Exception request controller: the driving end of the CPU's `expSrc0..2` exception inputs. It synchronizes and debounces raw external event lines, latches them as pending, and presents one prioritized request at a time to `single_cycle_cpu_top`. It holds the request until the CPU acknowledges entry into the handler, then waits for handler return before issuing the next request. It sits beside the CPU core in the top level, replacing direct tie-off or bench driving of `expSrc*`.

## Interface

**Parameters**
- `N_SRC`, default 3: number of event sources; bit i maps to `expSrc<i>`.
- `SYNC_STAGES`, default 2: synchronizer flops per source, ≥2.
- `DEB_CYCLES`, default 4: consecutive synchronized-high cycles required to qualify an event, ≥1.

**Ports**
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `evt_in` in N_SRC: raw asynchronous event lines, active-high.
- `evt_mask` in N_SRC: 1 = source enabled.
- `int_ack` in 1: one-cycle pulse from the CPU on exception entry.
- `int_done` in 1: one-cycle pulse from the CPU on handler return (eret).
- `exp_src` out N_SRC: one-hot request level to the CPU `expSrc*` inputs.
- `exp_cause` out 2: index of the current or last-granted source.
- `busy` out 1: high in the SERVICE state.
- `pending` out N_SRC: latched, not-yet-granted events.
- `drop_count` out 16: number of events lost because their source was already pending.

## Operation

**Per-source front end**
- Synchronize `evt_in[i]` through `SYNC_STAGES` flops.
- Counter `deb_cnt` increments while the synchronized value is high and saturates at `DEB_CYCLES`. It clears to 0 when the synchronized value is low.
- The debounced level is high iff `deb_cnt == DEB_CYCLES`.
- A rising edge of the debounced level produces a one-cycle qualification pulse `evt_q[i]`.

**Pending register**
- `evt_q[i]` sets `pending[i]`.
- If `pending[i]` is already 1 when `evt_q[i]` fires, `drop_count` increments. `drop_count` saturates at 0xFFFF.
- The grant at `int_ack` clears `pending[winner]`.
- If `evt_q[winner]` fires in the same cycle as that clear, set wins: the bit stays 1 and the event is not counted as dropped.
- Masking does not clear `pending`. Masked events still latch.

**Arbitration**
- `eligible = pending & evt_mask`.
- Fixed priority: lowest index wins, so `expSrc0` is highest.

**FSM states: IDLE, REQ, SERVICE**
- IDLE: `exp_src = 0`. If `eligible != 0`, latch winner index into `win` and `exp_cause`, then go to REQ.
- REQ: `exp_src = onehot(win)`.
  - If `int_ack`: clear `pending[win]` and go to SERVICE.
  - Else if `eligible[win] == 0` (mask withdrawn): go to IDLE. `exp_src` drops the next cycle.
  - A higher-priority source becoming eligible in REQ does not preempt.
- SERVICE: `exp_src = 0`, `busy = 1`. On `int_done`, go to IDLE. No nesting.
- `int_ack` outside REQ is ignored. `int_done` outside SERVICE is ignored.
- `int_ack` and `int_done` in the same cycle are evaluated by the current state only.

## Timing

- All outputs are registered.
- Reset values: `exp_src = 0`, `exp_cause = 0`, `busy = 0`, `pending = 0`, `drop_count = 0`, state IDLE. Synchronizers and `deb_cnt` also reset to 0.
- Reset asserted mid-operation returns to IDLE immediately and asynchronously. A pending request is lost.
- Latency:
  - `evt_in` high with mask set, counted from the first edge sampling it: `pending` sets after `SYNC_STAGES + DEB_CYCLES` edges.
  - `exp_src` asserts one edge after that: 7 edges with defaults.
  - The FSM leaves IDLE on the edge after `eligible` goes nonzero.
- Minimum spacing between back-to-back grants: `int_ack` edge → SERVICE → `int_done` edge → IDLE → REQ on the next edge. `exp_src` reasserts 2 edges after `int_done` is sampled.
- Pulses shorter than `DEB_CYCLES` synchronized cycles are rejected.
- An event held high indefinitely counts once. It must fall and re-qualify to fire again.

## Structure

- Shared package / header `exp_ctrl_pkg`:
  - FSM state encoding (IDLE = 0, REQ = 1, SERVICE = 2).
  - Cause width (2).
  - Saturation constant for `drop_count`.
- Sub-module `evt_debounce`: one instance per source via generate. Contains the synchronizer, debounce counter and rise detector; outputs `evt_q`.
- The top of `exp_req_ctrl` holds the pending register, priority encoder, FSM and drop counter.

## Test plan

- Reset, then `evt_in = 3'b001` held, mask `3'b111` → `pending[0] = 1` after 6 edges, `exp_src = 001` and `exp_cause = 0` after 7 edges. `int_ack` → `exp_src = 000`, `busy = 1`, `pending = 000`. `int_done` → `busy = 0`.
- `evt_in[2]` pulse of 3 cycles → no `pending` and no `exp_src`, since 3 < `DEB_CYCLES`. A pulse of 6 cycles → `pending[2] = 1` and `exp_src = 100`.
- `evt_in = 3'b110` simultaneously → grant 1 first. After ack/done, `exp_src = 100` two edges after `int_done`.
- In REQ for source 1, clear `evt_mask[1]` → FSM returns to IDLE, `exp_src = 000`, `pending[1]` still 1. Re-enable the mask → `exp_src = 010` again.
- Source 0 re-qualifies while `pending[0] = 1` → `drop_count = 1`. A re-qualification in the exact `int_ack` cycle → `pending[0]` stays 1 and `drop_count` is unchanged.
- Assert `rst` while in SERVICE with `pending = 3'b101` → all outputs zero immediately. `int_done` afterwards is ignored.
